// File: rtl/axi_ram_arbiter.sv
// 2:1 AXI4 arbiter sharing one axi_ram slave port between masters s0 and s1.
// Optional build macro AXI_RAM_ARBITER_FIXED_PRIORITY_EN: s0 always wins simultaneous requests.
module axi_ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0
  input  logic [ID_WIDTH-1:0]   s0_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
  input  logic [7:0]            s0_axi_awlen,
  input  logic [2:0]            s0_axi_awsize,
  input  logic [1:0]            s0_axi_awburst,
  input  logic                  s0_axi_awvalid,
  output logic                  s0_axi_awready,
  input  logic [DATA_WIDTH-1:0] s0_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axi_wstrb,
  input  logic                  s0_axi_wlast,
  input  logic                  s0_axi_wvalid,
  output logic                  s0_axi_wready,
  output logic [ID_WIDTH-1:0]   s0_axi_bid,
  output logic [1:0]            s0_axi_bresp,
  output logic                  s0_axi_bvalid,
  input  logic                  s0_axi_bready,
  input  logic [ID_WIDTH-1:0]   s0_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic [7:0]            s0_axi_arlen,
  input  logic [2:0]            s0_axi_arsize,
  input  logic [1:0]            s0_axi_arburst,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [ID_WIDTH-1:0]   s0_axi_rid,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]            s0_axi_rresp,
  output logic                  s0_axi_rlast,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  // master 1
  input  logic [ID_WIDTH-1:0]   s1_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
  input  logic [7:0]            s1_axi_awlen,
  input  logic [2:0]            s1_axi_awsize,
  input  logic [1:0]            s1_axi_awburst,
  input  logic                  s1_axi_awvalid,
  output logic                  s1_axi_awready,
  input  logic [DATA_WIDTH-1:0] s1_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axi_wstrb,
  input  logic                  s1_axi_wlast,
  input  logic                  s1_axi_wvalid,
  output logic                  s1_axi_wready,
  output logic [ID_WIDTH-1:0]   s1_axi_bid,
  output logic [1:0]            s1_axi_bresp,
  output logic                  s1_axi_bvalid,
  input  logic                  s1_axi_bready,
  input  logic [ID_WIDTH-1:0]   s1_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic [7:0]            s1_axi_arlen,
  input  logic [2:0]            s1_axi_arsize,
  input  logic [1:0]            s1_axi_arburst,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [ID_WIDTH-1:0]   s1_axi_rid,
  output logic [DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]            s1_axi_rresp,
  output logic                  s1_axi_rlast,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  // shared port toward axi_ram
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

`ifdef AXI_RAM_ARBITER_FIXED_PRIORITY_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  logic    wgrant_q, wgrant_d, wprio_q, wprio_d;
  logic    rgrant_q, rgrant_d, rprio_q, rprio_d;

  // Grant index: the pointer only breaks ties; a lone requester always wins.
  function automatic logic pick(input logic v0, input logic v1, input logic prio);
    if (v0 && v1) return FixedPrio ? 1'b0 : prio;
    return v1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      wgrant_q <= 1'b0;
      rgrant_q <= 1'b0;
      wprio_q  <= 1'b0;
      rprio_q  <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      wgrant_q <= wgrant_d;
      rgrant_q <= rgrant_d;
      wprio_q  <= wprio_d;
      rprio_q  <= rprio_d;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    wgrant_d = wgrant_q;
    wprio_d  = wprio_q;
    unique case (wstate_q)
      W_IDLE: if (s0_axi_awvalid || s1_axi_awvalid) begin
        wgrant_d = pick(s0_axi_awvalid, s1_axi_awvalid, wprio_q);
        wstate_d = W_ADDR;
      end
      W_ADDR: if (m_axi_awvalid && m_axi_awready) wstate_d = W_DATA;
      W_DATA: if (m_axi_wvalid && m_axi_wready && m_axi_wlast) wstate_d = W_RESP;
      W_RESP: if (m_axi_bvalid && m_axi_bready) begin
        wprio_d  = ~wgrant_q;
        wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rgrant_d = rgrant_q;
    rprio_d  = rprio_q;
    unique case (rstate_q)
      R_IDLE: if (s0_axi_arvalid || s1_axi_arvalid) begin
        rgrant_d = pick(s0_axi_arvalid, s1_axi_arvalid, rprio_q);
        rstate_d = R_ADDR;
      end
      R_ADDR: if (m_axi_arvalid && m_axi_arready) rstate_d = R_DATA;
      R_DATA: if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
        rprio_d  = ~rgrant_q;
        rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  logic aw_ph, w_ph, b_ph, ar_ph, r_ph;
  assign aw_ph = (wstate_q == W_ADDR);
  assign w_ph  = (wstate_q == W_DATA);
  assign b_ph  = (wstate_q == W_RESP);
  assign ar_ph = (rstate_q == R_ADDR);
  assign r_ph  = (rstate_q == R_DATA);

  // Write path: payload follows the grant, valids/readies gated by phase.
  assign m_axi_awid     = wgrant_q ? s1_axi_awid    : s0_axi_awid;
  assign m_axi_awaddr   = wgrant_q ? s1_axi_awaddr  : s0_axi_awaddr;
  assign m_axi_awlen    = wgrant_q ? s1_axi_awlen   : s0_axi_awlen;
  assign m_axi_awsize   = wgrant_q ? s1_axi_awsize  : s0_axi_awsize;
  assign m_axi_awburst  = wgrant_q ? s1_axi_awburst : s0_axi_awburst;
  assign m_axi_awvalid  = aw_ph && (wgrant_q ? s1_axi_awvalid : s0_axi_awvalid);
  assign s0_axi_awready = aw_ph && !wgrant_q && m_axi_awready;
  assign s1_axi_awready = aw_ph &&  wgrant_q && m_axi_awready;

  assign m_axi_wdata    = wgrant_q ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_wstrb    = wgrant_q ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_wlast    = wgrant_q ? s1_axi_wlast : s0_axi_wlast;
  assign m_axi_wvalid   = w_ph && (wgrant_q ? s1_axi_wvalid : s0_axi_wvalid);
  assign s0_axi_wready  = w_ph && !wgrant_q && m_axi_wready;
  assign s1_axi_wready  = w_ph &&  wgrant_q && m_axi_wready;

  assign s0_axi_bid     = m_axi_bid;
  assign s1_axi_bid     = m_axi_bid;
  assign s0_axi_bresp   = m_axi_bresp;
  assign s1_axi_bresp   = m_axi_bresp;
  assign s0_axi_bvalid  = b_ph && !wgrant_q && m_axi_bvalid;
  assign s1_axi_bvalid  = b_ph &&  wgrant_q && m_axi_bvalid;
  assign m_axi_bready   = b_ph && (wgrant_q ? s1_axi_bready : s0_axi_bready);

  // Read path
  assign m_axi_arid     = rgrant_q ? s1_axi_arid    : s0_axi_arid;
  assign m_axi_araddr   = rgrant_q ? s1_axi_araddr  : s0_axi_araddr;
  assign m_axi_arlen    = rgrant_q ? s1_axi_arlen   : s0_axi_arlen;
  assign m_axi_arsize   = rgrant_q ? s1_axi_arsize  : s0_axi_arsize;
  assign m_axi_arburst  = rgrant_q ? s1_axi_arburst : s0_axi_arburst;
  assign m_axi_arvalid  = ar_ph && (rgrant_q ? s1_axi_arvalid : s0_axi_arvalid);
  assign s0_axi_arready = ar_ph && !rgrant_q && m_axi_arready;
  assign s1_axi_arready = ar_ph &&  rgrant_q && m_axi_arready;

  assign s0_axi_rid     = m_axi_rid;
  assign s1_axi_rid     = m_axi_rid;
  assign s0_axi_rdata   = m_axi_rdata;
  assign s1_axi_rdata   = m_axi_rdata;
  assign s0_axi_rresp   = m_axi_rresp;
  assign s1_axi_rresp   = m_axi_rresp;
  assign s0_axi_rlast   = m_axi_rlast;
  assign s1_axi_rlast   = m_axi_rlast;
  assign s0_axi_rvalid  = r_ph && !rgrant_q && m_axi_rvalid;
  assign s1_axi_rvalid  = r_ph &&  rgrant_q && m_axi_rvalid;
  assign m_axi_rready   = r_ph && (rgrant_q ? s1_axi_rready : s0_axi_rready);

endmodule

// File: tb/tb_axi_ram_arbiter.sv
// Bench for axi_ram_arbiter with a small behavioural axi_ram on the shared port.
module tb_axi_ram_arbiter;

  localparam int TO = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  s_awid[2];    logic [15:0] s_awaddr[2]; logic [7:0] s_awlen[2];
  logic [2:0]  s_awsize[2];  logic [1:0]  s_awburst[2];
  logic        s_awvalid[2]; logic        s_awready[2];
  logic [31:0] s_wdata[2];   logic [3:0]  s_wstrb[2];
  logic        s_wlast[2];   logic        s_wvalid[2]; logic s_wready[2];
  logic [7:0]  s_bid[2];     logic [1:0]  s_bresp[2];
  logic        s_bvalid[2];  logic        s_bready[2];
  logic [7:0]  s_arid[2];    logic [15:0] s_araddr[2]; logic [7:0] s_arlen[2];
  logic [2:0]  s_arsize[2];  logic [1:0]  s_arburst[2];
  logic        s_arvalid[2]; logic        s_arready[2];
  logic [7:0]  s_rid[2];     logic [31:0] s_rdata[2];  logic [1:0] s_rresp[2];
  logic        s_rlast[2];   logic        s_rvalid[2]; logic s_rready[2];

  logic [7:0]  m_awid, m_arid, m_bid, m_rid, m_awlen, m_arlen;
  logic [15:0] m_awaddr, m_araddr;
  logic [2:0]  m_awsize, m_arsize;
  logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

  axi_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_axi_awid(s_awid[0]), .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awlen(s_awlen[0]),
    .s0_axi_awsize(s_awsize[0]), .s0_axi_awburst(s_awburst[0]), .s0_axi_awvalid(s_awvalid[0]),
    .s0_axi_awready(s_awready[0]), .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]),
    .s0_axi_wlast(s_wlast[0]), .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(s_wready[0]),
    .s0_axi_bid(s_bid[0]), .s0_axi_bresp(s_bresp[0]), .s0_axi_bvalid(s_bvalid[0]),
    .s0_axi_bready(s_bready[0]), .s0_axi_arid(s_arid[0]), .s0_axi_araddr(s_araddr[0]),
    .s0_axi_arlen(s_arlen[0]), .s0_axi_arsize(s_arsize[0]), .s0_axi_arburst(s_arburst[0]),
    .s0_axi_arvalid(s_arvalid[0]), .s0_axi_arready(s_arready[0]), .s0_axi_rid(s_rid[0]),
    .s0_axi_rdata(s_rdata[0]), .s0_axi_rresp(s_rresp[0]), .s0_axi_rlast(s_rlast[0]),
    .s0_axi_rvalid(s_rvalid[0]), .s0_axi_rready(s_rready[0]),
    .s1_axi_awid(s_awid[1]), .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awlen(s_awlen[1]),
    .s1_axi_awsize(s_awsize[1]), .s1_axi_awburst(s_awburst[1]), .s1_axi_awvalid(s_awvalid[1]),
    .s1_axi_awready(s_awready[1]), .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]),
    .s1_axi_wlast(s_wlast[1]), .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(s_wready[1]),
    .s1_axi_bid(s_bid[1]), .s1_axi_bresp(s_bresp[1]), .s1_axi_bvalid(s_bvalid[1]),
    .s1_axi_bready(s_bready[1]), .s1_axi_arid(s_arid[1]), .s1_axi_araddr(s_araddr[1]),
    .s1_axi_arlen(s_arlen[1]), .s1_axi_arsize(s_arsize[1]), .s1_axi_arburst(s_arburst[1]),
    .s1_axi_arvalid(s_arvalid[1]), .s1_axi_arready(s_arready[1]), .s1_axi_rid(s_rid[1]),
    .s1_axi_rdata(s_rdata[1]), .s1_axi_rresp(s_rresp[1]), .s1_axi_rlast(s_rlast[1]),
    .s1_axi_rvalid(s_rvalid[1]), .s1_axi_rready(s_rready[1]),
    .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
    .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst), .m_axi_awvalid(m_awvalid),
    .m_axi_awready(m_awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
    .m_axi_wlast(m_wlast), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
    .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arvalid(m_arvalid),
    .m_axi_arready(m_arready), .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
    .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
  );

  // Behavioural RAM slave: one write and one read burst in flight, INCR, full words.
  logic [31:0] mem[256];
  logic        wbusy, bpend, rbusy;
  logic [15:0] waddr, raddr;
  logic [7:0]  wid, rid_q, rcnt;

  assign m_awready = !wbusy;
  assign m_wready  = wbusy && !bpend;
  assign m_bvalid  = bpend;
  assign m_bid     = wid;
  assign m_bresp   = 2'b00;
  assign m_arready = !rbusy;
  assign m_rvalid  = rbusy;
  assign m_rdata   = mem[raddr[9:2]];
  assign m_rid     = rid_q;
  assign m_rresp   = 2'b00;
  assign m_rlast   = (rcnt == 8'd0);

  always @(posedge clk) begin
    if (rst) begin
      wbusy <= 1'b0; bpend <= 1'b0; rbusy <= 1'b0;
      waddr <= '0; raddr <= '0; wid <= '0; rid_q <= '0; rcnt <= '0;
    end else begin
      if (m_awvalid && m_awready) begin
        wbusy <= 1'b1; waddr <= m_awaddr; wid <= m_awid;
      end
      if (m_wvalid && m_wready) begin
        mem[waddr[9:2]] <= m_wdata;
        waddr <= waddr + 16'd4;
        if (m_wlast) bpend <= 1'b1;
      end
      if (m_bvalid && m_bready) begin
        bpend <= 1'b0; wbusy <= 1'b0;
      end
      if (m_arvalid && m_arready) begin
        rbusy <= 1'b1; raddr <= m_araddr; rcnt <= m_arlen; rid_q <= m_arid;
      end
      if (m_rvalid && m_rready) begin
        if (rcnt == 8'd0) rbusy <= 1'b0;
        else begin
          rcnt <= rcnt - 8'd1; raddr <= raddr + 16'd4;
        end
      end
    end
  end

  // Monitor: AW grant order, W accepted before own AW, misrouted responses, s1 activity.
  int   aw_order[$];
  logic [1:0] aw_done;
  int   wviol, misroute, s1_act, s1_wstall;
  logic watch_s1;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) aw_done[i] <= 1'b0;
      else begin
        if (s_awvalid[i] && s_awready[i]) begin
          aw_done[i] <= 1'b1;
          aw_order.push_back(i);
        end
        if (s_bvalid[i] && s_bready[i]) aw_done[i] <= 1'b0;
        if (s_wvalid[i] && s_wready[i] && !aw_done[i]) wviol <= wviol + 1;
      end
      if (s_rvalid[i] && (s_rid[i][7] != 1'(i))) misroute <= misroute + 1;
      if (s_bvalid[i] && (s_bid[i][7] != 1'(i))) misroute <= misroute + 1;
    end
    if (watch_s1 && (s_awready[1] || s_wready[1] || s_arready[1] || s_bvalid[1] || s_rvalid[1]))
      s1_act <= s1_act + 1;
    if (s_wvalid[1] && !s_wready[1]) s1_wstall <= s1_wstall + 1;
  end

  int checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int ch, input int i);
    case (ch)
      0: return s_awready[i];
      1: return s_wready[i];
      2: return s_bvalid[i];
      3: return s_arready[i];
      default: return s_rvalid[i];
    endcase
  endfunction

  // Called just after a negedge; returns with the handshake due at the next posedge.
  task automatic wait_on(input int ch, input int i, input string name);
    int n;
    for (n = 0; n < TO; n++) begin
      #1;
      if (rdy(ch, i)) break;
      @(negedge clk);
    end
    if (n == TO) begin
      checks++; errors++;
      $display("FAIL timeout %s master %0d", name, i);
    end
  endtask

  function automatic logic [15:0] outs();
    return {s_awready[0], s_awready[1], s_wready[0], s_wready[1], s_arready[0], s_arready[1],
            s_bvalid[0], s_bvalid[1], s_rvalid[0], s_rvalid[1],
            m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, 1'b0};
  endfunction

  // Beat k of a burst carries seed*(k+1).
  task automatic wr(input int i, input logic [7:0] id, input logic [15:0] addr, input int len,
                    input logic [31:0] seed);
    fork
      begin
        @(negedge clk);
        s_awid[i] = id; s_awaddr[i] = addr; s_awlen[i] = 8'(len);
        s_awsize[i] = 3'd2; s_awburst[i] = 2'b01; s_awvalid[i] = 1'b1;
        wait_on(0, i, "aw");
        @(negedge clk);
        s_awvalid[i] = 1'b0;
      end
      begin
        @(negedge clk);
        for (int k = 0; k <= len; k++) begin
          s_wdata[i] = seed * 32'(k + 1); s_wstrb[i] = 4'hF;
          s_wlast[i] = (k == len); s_wvalid[i] = 1'b1;
          wait_on(1, i, "w");
          @(negedge clk);
        end
        s_wvalid[i] = 1'b0; s_wlast[i] = 1'b0;
      end
    join
    s_bready[i] = 1'b1;
    wait_on(2, i, "b");
    chk("bid", 32'(s_bid[i]), 32'(id));
    chk("bresp", 32'(s_bresp[i]), 32'd0);
    @(negedge clk);
    s_bready[i] = 1'b0;
  endtask

  task automatic rd(input int i, input logic [7:0] id, input logic [15:0] addr, input int len,
                    input logic [31:0] seed, input int stall_at);
    logic [31:0] held;
    @(negedge clk);
    s_arid[i] = id; s_araddr[i] = addr; s_arlen[i] = 8'(len);
    s_arsize[i] = 3'd2; s_arburst[i] = 2'b01; s_arvalid[i] = 1'b1;
    wait_on(3, i, "ar");
    @(negedge clk);
    s_arvalid[i] = 1'b0; s_rready[i] = 1'b1;
    for (int k = 0; k <= len; k++) begin
      wait_on(4, i, "r");
      if (k == stall_at) begin
        s_rready[i] = 1'b0;
        held = s_rdata[i];
        for (int c = 0; c < 5; c++) begin
          @(negedge clk); #1;
          chk("stall_rvalid", 32'(s_rvalid[i]), 32'd1);
          chk("stall_rdata", s_rdata[i], held);
          chk("stall_other_arready", 32'(s_arready[1-i]), 32'd0);
        end
        s_rready[i] = 1'b1;
      end
      chk("rdata", s_rdata[i], seed * 32'(k + 1));
      chk("rid", 32'(s_rid[i]), 32'(id));
      chk("rlast", 32'(s_rlast[i]), 32'(k == len));
      @(negedge clk);
    end
    s_rready[i] = 1'b0;
  endtask

  typedef struct {
    bit req0;
    bit req1;
    int exp0;
    int exp1;
  } arb_vec_t;

  arb_vec_t vecs[8];

  function automatic int q_at(input int idx);
    if (idx < aw_order.size()) return aw_order[idx];
    return 99;
  endfunction

  initial begin
    int base, stall0;

    // Expected grant order after a fresh reset; -1 marks no second grant.
    vecs[0] = '{1'b1, 1'b1, 0, 1};
    vecs[1] = '{1'b0, 1'b1, 1, -1};
    vecs[2] = '{1'b1, 1'b0, 0, -1};
`ifdef AXI_RAM_ARBITER_FIXED_PRIORITY_EN
    vecs[3] = '{1'b1, 1'b1, 0, 1};
    vecs[4] = '{1'b1, 1'b1, 0, 1};
`else
    vecs[3] = '{1'b1, 1'b1, 1, 0};
    vecs[4] = '{1'b1, 1'b1, 1, 0};
`endif
    vecs[5] = '{1'b0, 1'b1, 1, -1};
    vecs[6] = '{1'b1, 1'b1, 0, 1};
    vecs[7] = '{1'b1, 1'b1, 0, 1};

    for (int i = 0; i < 2; i++) begin
      s_awid[i] = '0; s_awaddr[i] = '0; s_awlen[i] = '0; s_awsize[i] = '0; s_awburst[i] = '0;
      s_awvalid[i] = 1'b0; s_wdata[i] = '0; s_wstrb[i] = '0; s_wlast[i] = 1'b0;
      s_wvalid[i] = 1'b0; s_bready[i] = 1'b0; s_arid[i] = '0; s_araddr[i] = '0;
      s_arlen[i] = '0; s_arsize[i] = '0; s_arburst[i] = '0; s_arvalid[i] = 1'b0;
      s_rready[i] = 1'b0;
    end
    watch_s1 = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;

    // Single-master burst and read-back; s1 must see nothing.
    watch_s1 = 1'b1;
    wr(0, 8'h01, 16'h0010, 3, 32'h11);
    rd(0, 8'h02, 16'h0010, 3, 32'h11, -1);
    watch_s1 = 1'b0;
    chk("s1_quiet", 32'(s1_act), 32'd0);

    // Arbitration table from a known pointer state.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int v = 0; v < 8; v++) begin
      base = aw_order.size();
      fork
        begin if (vecs[v].req0) wr(0, 8'h10 + 8'(v), 16'h0300, 0, 32'h100 + 32'(v)); end
        begin if (vecs[v].req1) wr(1, 8'h90 + 8'(v), 16'h0304, 1, 32'h200 + 32'(v)); end
      join
      @(negedge clk);
      chk("arb_count", 32'(aw_order.size() - base), (vecs[v].exp1 < 0) ? 32'd1 : 32'd2);
      chk("arb_first", 32'(q_at(base)), 32'(vecs[v].exp0));
      if (vecs[v].exp1 >= 0) chk("arb_second", 32'(q_at(base + 1)), 32'(vecs[v].exp1));
    end

    // s1 presents W early while s0 owns the write path.
    stall0 = s1_wstall;
    fork
      wr(0, 8'h03, 16'h0040, 3, 32'h5);
      begin
        repeat (2) @(negedge clk);
        wr(1, 8'h83, 16'h0080, 0, 32'hDEAD);
      end
    join
    chk("s1_w_stalled", 32'(s1_wstall - stall0 > 2), 32'd1);
    rd(1, 8'h84, 16'h0080, 0, 32'hDEAD, -1);

    // Concurrent read by s0 and write by s1.
    wr(0, 8'h04, 16'h0200, 7, 32'h0101_0101);
    fork
      rd(0, 8'h05, 16'h0200, 7, 32'h0101_0101, -1);
      wr(1, 8'h85, 16'h0100, 7, 32'h0202_0202);
    join
    rd(1, 8'h86, 16'h0100, 7, 32'h0202_0202, -1);

    // Backpressure on s0's R with s1 queued behind it.
    fork
      rd(0, 8'h06, 16'h0010, 3, 32'h11, 1);
      begin
        repeat (2) @(negedge clk);
        rd(1, 8'h87, 16'h0080, 0, 32'hDEAD, -1);
      end
    join

    // Reset in the middle of a write data phase.
    @(negedge clk);
    s_awid[0] = 8'h07; s_awaddr[0] = 16'h0380; s_awlen[0] = 8'd3;
    s_awsize[0] = 3'd2; s_awburst[0] = 2'b01; s_awvalid[0] = 1'b1;
    wait_on(0, 0, "aw_rst");
    @(negedge clk);
    s_awvalid[0] = 1'b0;
    #1 chk("in_wdata_wready", 32'(s_wready[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid_outputs", 32'(outs()), 32'd0);
    wr(1, 8'h88, 16'h0390, 0, 32'h77);
    rd(1, 8'h89, 16'h0390, 0, 32'h77, -1);

    chk("w_before_aw", 32'(wviol), 32'd0);
    chk("misroute", 32'(misroute), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_ram_arbiter.md
Name: axi_ram_arbiter

Overview:
- 2:1 AXI4 arbiter that shares one axi_ram slave port between two upstream masters, s0 and s1.
- Read and write paths are arbitrated independently, each by a round-robin scheduler.
- A grant is held for a whole transaction:
  - write: from the address phase until the B handshake;
  - read: from the AR handshake until the last R beat.
- Sits directly in front of axi_ram; all channels are forwarded combinationally once a grant is registered.

Parameters:
- DATA_WIDTH, 32, data bus width; must match axi_ram.
- ADDR_WIDTH, 16, address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- ID_WIDTH, 8, AXI ID width; IDs pass through unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sN_axi_aw{id,addr,len,size,burst,valid}  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1  master N write address (N=0,1).
- sN_axi_awready  out  1  master N AW ready.
- sN_axi_w{data,strb,last,valid}  in  DATA_WIDTH/STRB_WIDTH/1/1  master N write data.
- sN_axi_wready  out  1  master N W ready.
- sN_axi_b{id,resp,valid}  out  ID_WIDTH/2/1  master N write response.
- sN_axi_bready  in  1  master N B ready.
- sN_axi_ar{id,addr,len,size,burst,valid}  in  as AW  master N read address.
- sN_axi_arready  out  1  master N AR ready.
- sN_axi_r{id,data,resp,last,valid}  out  ID_WIDTH/DATA_WIDTH/2/1/1  master N read data.
- sN_axi_rready  in  1  master N R ready.
- m_axi_*  mirror set toward axi_ram: AW/W/AR payload and valids out, B/R payload and valids in, readies in the opposite direction.

Behaviour:
- Reset (synchronous, rst=1):
  - both FSMs go to IDLE;
  - every valid and ready output is 0;
  - both round-robin pointers prefer s0.
- Write FSM: IDLE -> WADDR -> WDATA -> WRESP -> IDLE.
  - IDLE: if any sN_axi_awvalid is high, register wgrant per the round-robin pointer and go to WADDR. One cycle of arbitration latency; no ready is asserted in IDLE.
  - WADDR: m_axi_aw* = granted sN_axi_aw*, and sN_axi_awready = m_axi_awready for the granted master only. On the AW handshake go to WDATA.
  - WDATA: W is forwarded the same way. On a W handshake with wlast=1 go to WRESP.
  - WRESP: m_axi_b* is routed to the granted master and m_axi_bready = granted sN_axi_bready. On the B handshake, set the pointer to prefer the other master and go to IDLE.
- Read FSM: IDLE -> RADDR -> RDATA -> IDLE.
  - Grant rule is the same as for writes.
  - In RDATA, R is routed to the granted master.
  - On an R handshake with rlast=1, update the pointer and go to IDLE.
- Non-granted master:
  - its ready and valid outputs are held at 0;
  - B/R payload fields are broadcast to both masters, and only the valids are gated.
- Outside WADDR/WDATA/RADDR, m_axi_awvalid, m_axi_wvalid and m_axi_arvalid are 0.
- Simultaneous requests: the pointer decides. A single requester always wins regardless of the pointer.
- W data arriving before AW, or during another master's burst, sees wready=0 and stalls; it is never dropped.
- A requester's valid may drop while in IDLE; only valids present in the decision cycle count.
- Read and write grants may belong to different masters concurrently.
- Reset mid-transaction: FSMs return to IDLE on the next clock. axi_ram shares rst, so no drain is performed.
- resp fields pass through unchanged (axi_ram returns 2'b00).

Optional Feature:
- Macro: AXI_RAM_ARBITER_FIXED_PRIORITY_EN.
- Defined: s0 always wins simultaneous requests and the pointers are unused. s1 is granted only when s0's valid is low in the IDLE decision cycle.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
- Reset, then s0 writes awaddr=0x0010, awlen=3, data 0x11..0x44:
  - s1 readies stay 0 throughout;
  - s0_bvalid=1 with bid = s0 awid;
  - a read back returns 0x11,0x22,0x33,0x44 with rlast on beat 4.
- s0 and s1 both assert awvalid in the same cycle, lengths 0 and 1:
  - s0 granted first, then s1;
  - repeated simultaneous requests alternate s0,s1,s0,s1.
- s1 asserts wvalid with data 0xDEAD while s0's 4-beat burst is active:
  - s1_wready stays 0 until s1's AW is granted;
  - 0xDEAD is then written at s1's awaddr.
- Concurrent traffic: s0 reads (arlen=7) while s1 writes (awlen=7):
  - both complete;
  - rid/bid match the issuing masters;
  - no beat is routed to the wrong master.
- rready=0 on s0 for 5 cycles mid-burst:
  - the R beat is held stable;
  - the grant is kept;
  - s1's arvalid waits.
- rst asserted during WDATA:
  - all valid and ready outputs are 0 the next cycle;
  - a fresh s1 request is then granted normally.
- Macro defined, continuous simultaneous requests: s0 wins every arbitration.
